mii_rmii_tx: RTL and testbench
==============================

Name: mii_rmii_tx

Overview:
- PHY-side end of the MII transmit path: presents an MII TX port to the MAC and drives an RMII transmit port toward the PHY.
- Runs from the 50 MHz RMII reference clock.
- Generates mii_tx_clk for the MAC, captures each MAC nibble mid-period, and serialises it as two RMII dibits, low dibit first.
- Supports 100 Mbps and 10 Mbps; at 10 Mbps each dibit is held for 10 clocks.

Parameters:
- DEFAULT_SPEED_100, 1, speed adopted out of reset (1 = 100 Mbps, 0 = 10 Mbps).
- ERR_COUNT_WIDTH, 16, width of the saturating tx_er nibble counter.

Ports:
- clk  in  1  50 MHz RMII reference clock; sole clock
- rst_n  in  1  asynchronous active-low reset
- speed_100  in  1  requested speed; applied only at idle nibble boundaries
- mii_tx_clk  out  1  generated MII TX clock: 25 MHz at 100 Mbps, 2.5 MHz at 10 Mbps
- mii_txd  in  4  MAC transmit nibble
- mii_tx_en  in  1  MAC transmit enable
- mii_tx_er  in  1  MAC transmit error
- rmii_txd  out  2  RMII transmit dibit
- rmii_tx_en  out  1  RMII transmit enable
- tx_err_pulse  out  1  one-clk pulse per captured nibble with tx_en=1 and tx_er=1
- odd_nibble_pulse  out  1  one-clk pulse when a frame ends after an odd nibble count
- err_count  out  ERR_COUNT_WIDTH  saturating count of errored nibbles; cleared only by reset

Behaviour:
- Reset (async assert, sync release): cnt=0, mii_tx_clk=0, rmii_txd=00, rmii_tx_en=0, both pulses 0, err_count=0, speed_reg=DEFAULT_SPEED_100, nibble parity=0.
- Nibble period N: 2 when speed_reg=1, 20 when speed_reg=0.
- cnt runs 0..N-1, wrapping at N-1.
- mii_tx_clk is registered and equals 1 while cnt < N/2. Its first rising edge occurs on the first clk after reset release.
- Capture edge is the clk edge where cnt goes from N/2-1 to N/2 (the falling edge of mii_tx_clk). On this edge:
  - mii_txd, mii_tx_en and mii_tx_er are sampled.
  - The upper dibit is held in hold_hi.
  - rmii_txd <= mii_txd[1:0] and rmii_tx_en <= mii_tx_en.
- Second-dibit edge is the clk edge where cnt goes from N-1 to 0. On this edge rmii_txd <= hold_hi, and rmii_tx_en keeps its captured value.
- Each dibit is therefore held N/2 clocks: 1 clk at 100 Mbps, 10 clks at 10 Mbps.
- Latency: a nibble launched by the MAC on a mii_tx_clk rising edge appears on rmii_txd N/2 clocks later (1 clk at 100 Mbps, 10 clks at 10 Mbps).
- When the captured tx_en=0, both dibits are driven as 00.
- tx_er:
  - Captured tx_en=1 and tx_er=1: data passes unchanged, tx_err_pulse fires on the capture edge, and err_count increments, saturating at all-ones.
  - tx_er with tx_en=0 is ignored.
- Frame end: on a capture edge where the captured tx_en falls from 1 to 0, odd_nibble_pulse fires if the frame's nibble count was odd, then parity resets to 0. Parity toggles on every capture with tx_en=1.
- Speed change: speed_100 is sampled only on the N-1 to 0 edge, and only when rmii_tx_en=0 and the current capture has tx_en=0. The new N takes effect from cnt=0. Changes requested mid-frame wait until idle.
- Reset mid-frame: outputs drop to 0 immediately. No partial dibit is emitted after release, and the frame is not resumed.
- Simultaneous tx_er and frame end on the same capture cannot occur, because tx_er counts only when tx_en=1.

Decomposition:
- Shared package mii_rmii_pkg holds:
  - constants RMII_DIV_100=2 and RMII_DIV_10=20;
  - constants RMII_HALF_100=1 and RMII_HALF_10=10;
  - a typedef for the speed encoding.
- Sub-module mii_rmii_clk_div owns:
  - cnt, speed_reg and the mii_tx_clk register;
  - speed-change gating;
  - two single-clk strobes, cap_stb (into cnt=N/2) and hi_stb (into cnt=0).
- Top level contains the capture and serialiser registers, parity tracking and error counter.

Test Plan:
- 100 Mbps, MAC sends nibbles 5,5,D,A with tx_en=1 → rmii_txd sequence 01,01,01,01,01,11,10,10 on consecutive clks; rmii_tx_en=1 throughout; mii_tx_clk period is 2 clks.
- 10 Mbps, single nibble 0x9 → rmii_txd=01 for 10 clks then 10 for 10 clks; mii_tx_clk high for 10 clks and low for 10 clks.
- tx_er=1 with tx_en=1 on 3 nibbles → 3 tx_err_pulse, err_count=3, data unchanged. Separately, tx_er=1 with tx_en=0 → no pulse.
- Frame of 7 nibbles → one odd_nibble_pulse on the capture after the last nibble. Frame of 8 nibbles → no pulse.
- speed_100 driven 1→0 mid-frame → period stays 2 clks until tx_en has been 0 for one nibble; the next period is 20 clks.
- rst_n asserted mid-frame at 100 Mbps → rmii_tx_en, rmii_txd and mii_tx_clk go to 0 in the same cycle. After release, the first mii_tx_clk rise comes 1 clk later and rmii_tx_en stays 0 until the MAC reasserts tx_en.

Source files
------------

// File: rtl/mii_rmii_pkg.sv
// rtl/mii_rmii_pkg.sv - shared constants and speed encoding for the MII-to-RMII transmit path
package mii_rmii_pkg;
  localparam int RMII_DIV_100  = 2;
  localparam int RMII_DIV_10   = 20;
  localparam int RMII_HALF_100 = 1;
  localparam int RMII_HALF_10  = 10;
  localparam int CNT_WIDTH     = 5;

  typedef enum logic {
    SPEED_10  = 1'b0,
    SPEED_100 = 1'b1
  } speed_t;
endpackage

// File: rtl/mii_rmii_clk_div.sv
// rtl/mii_rmii_clk_div.sv - nibble-period counter, MII TX clock and capture/second-dibit strobes
module mii_rmii_clk_div
  import mii_rmii_pkg::*;
#(
  parameter bit DEFAULT_SPEED_100 = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic speed_100,
  input  logic idle,
  output logic tx_clk,
  output logic cap_stb,
  output logic hi_stb
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  speed_t               speed_reg;
  logic                 started;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] div;
  logic [CNT_WIDTH-1:0] half;

  // The first clock after reset only raises tx_clk; counting starts from there.
  always_comb begin
    div      = (speed_reg == SPEED_100) ? CNT_WIDTH'(RMII_DIV_100)  : CNT_WIDTH'(RMII_DIV_10);
    half     = (speed_reg == SPEED_100) ? CNT_WIDTH'(RMII_HALF_100) : CNT_WIDTH'(RMII_HALF_10);
    cap_stb  = started && (cnt == half - CNT_ONE);
    hi_stb   = started && (cnt == div - CNT_ONE);
    cnt_next = (!started || hi_stb) ? '0 : cnt + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      cnt       <= '0;
      tx_clk    <= 1'b0;
      speed_reg <= DEFAULT_SPEED_100 ? SPEED_100 : SPEED_10;
    end else begin
      started <= 1'b1;
      cnt     <= cnt_next;
      tx_clk  <= (cnt_next < half);
      if (hi_stb && idle)
        speed_reg <= speed_100 ? SPEED_100 : SPEED_10;
    end
  end
endmodule

// File: rtl/mii_rmii_tx.sv
// rtl/mii_rmii_tx.sv - MII transmit port to RMII dibit serialiser with tx_er and odd-nibble tracking
module mii_rmii_tx
  import mii_rmii_pkg::*;
#(
  parameter bit DEFAULT_SPEED_100 = 1'b1,
  parameter int ERR_COUNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       speed_100,
  output logic                       mii_tx_clk,
  input  logic [3:0]                 mii_txd,
  input  logic                       mii_tx_en,
  input  logic                       mii_tx_er,
  output logic [1:0]                 rmii_txd,
  output logic                       rmii_tx_en,
  output logic                       tx_err_pulse,
  output logic                       odd_nibble_pulse,
  output logic [ERR_COUNT_WIDTH-1:0] err_count
);
  localparam logic [ERR_COUNT_WIDTH-1:0] ERR_ONE = ERR_COUNT_WIDTH'(1);

  logic       cap_stb;
  logic       hi_stb;
  logic [1:0] hold_hi;
  logic       parity;

  // rmii_tx_en mirrors the captured tx_en, so it doubles as the speed-change idle gate.
  mii_rmii_clk_div #(
    .DEFAULT_SPEED_100(DEFAULT_SPEED_100)
  ) u_clk_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .speed_100(speed_100),
    .idle     (!rmii_tx_en),
    .tx_clk   (mii_tx_clk),
    .cap_stb  (cap_stb),
    .hi_stb   (hi_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rmii_txd         <= 2'b00;
      rmii_tx_en       <= 1'b0;
      hold_hi          <= 2'b00;
      parity           <= 1'b0;
      tx_err_pulse     <= 1'b0;
      odd_nibble_pulse <= 1'b0;
      err_count        <= '0;
    end else begin
      tx_err_pulse     <= 1'b0;
      odd_nibble_pulse <= 1'b0;
      if (cap_stb) begin
        rmii_tx_en <= mii_tx_en;
        if (mii_tx_en) begin
          rmii_txd <= mii_txd[1:0];
          hold_hi  <= mii_txd[3:2];
          parity   <= ~parity;
          if (mii_tx_er) begin
            tx_err_pulse <= 1'b1;
            if (err_count != '1)
              err_count <= err_count + ERR_ONE;
          end
        end else begin
          rmii_txd <= 2'b00;
          hold_hi  <= 2'b00;
          if (rmii_tx_en) begin
            odd_nibble_pulse <= parity;
            parity           <= 1'b0;
          end
        end
      end else if (hi_stb) begin
        rmii_txd <= hold_hi;
      end
    end
  end
endmodule

// File: tb/tb_mii_rmii_tx.sv
// tb/tb_mii_rmii_tx.sv - self-checking bench for mii_rmii_tx against a nibble-level reference model
module tb_mii_rmii_tx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        speed_100;
  logic        mii_tx_clk;
  logic [3:0]  mii_txd;
  logic        mii_tx_en;
  logic        mii_tx_er;
  logic [1:0]  rmii_txd;
  logic        rmii_tx_en;
  logic        tx_err_pulse;
  logic        odd_nibble_pulse;
  logic [15:0] err_count;

  mii_rmii_tx #(.DEFAULT_SPEED_100(1'b1), .ERR_COUNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .speed_100(speed_100), .mii_tx_clk(mii_tx_clk),
    .mii_txd(mii_txd), .mii_tx_en(mii_tx_en), .mii_tx_er(mii_tx_er),
    .rmii_txd(rmii_txd), .rmii_tx_en(rmii_tx_en), .tx_err_pulse(tx_err_pulse),
    .odd_nibble_pulse(odd_nibble_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       tclk_d = 1'b0;
  logic [1:0] mon_q[$];
  int         n_err_pulse = 0;
  int         n_odd_pulse = 0;
  logic [3:0] nib_q[$];
  bit         er_q[$];
  int         cur_half = 1;
  int         switch_at = -1;
  int         exp_err_total = 0;

  always @(posedge clk) tclk_d <= mii_tx_clk;

  always @(posedge clk) begin
    #1;
    if (rmii_tx_en === 1'b1) mon_q.push_back(rmii_txd);
    if (tx_err_pulse === 1'b1) n_err_pulse++;
    if (odd_nibble_pulse === 1'b1) n_odd_pulse++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(output int gap);
    bit ok = 0;
    gap = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      gap++;
      if (mii_tx_clk === 1'b1 && tclk_d === 1'b0) begin ok = 1; break; end
    end
    if (!ok) check("rise_timeout", 32'(gap), 32'(0));
  endtask

  task automatic run_frame(input string tag);
    int gap;
    bit gaps_ok = 1;
    int bad_idx = -1;
    int exp_err = 0;
    logic [1:0] exp_q[$];
    mon_q = {};
    n_err_pulse = 0;
    n_odd_pulse = 0;
    wait_rise(gap);
    for (int i = 0; i < nib_q.size(); i++) begin
      if (i == switch_at) speed_100 = 1'b0;
      mii_txd = nib_q[i]; mii_tx_en = 1'b1; mii_tx_er = er_q[i];
      wait_rise(gap);
      if (gap != 2 * cur_half) gaps_ok = 0;
    end
    mii_tx_en = 1'b0; mii_txd = 4'($urandom); mii_tx_er = 1'($urandom);
    wait_rise(gap);
    wait_rise(gap);
    mii_tx_er = 1'b0;
    foreach (nib_q[i]) begin
      repeat (cur_half) exp_q.push_back(nib_q[i][1:0]);
      repeat (cur_half) exp_q.push_back(nib_q[i][3:2]);
      if (er_q[i]) exp_err++;
    end
    exp_err_total += exp_err;
    foreach (exp_q[i])
      if (bad_idx < 0 && (i >= mon_q.size() || mon_q[i] !== exp_q[i])) bad_idx = i;
    check({tag, "_len"}, 32'(mon_q.size()), 32'(exp_q.size()));
    check({tag, "_first_bad_dibit"}, 32'(bad_idx), 32'(-1));
    check({tag, "_period"}, 32'(gaps_ok), 32'(1));
    check({tag, "_err_pulses"}, 32'(n_err_pulse), 32'(exp_err));
    check({tag, "_odd_pulses"}, 32'(n_odd_pulse), 32'(nib_q.size() % 2));
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_err_total));
  endtask

  task automatic random_frame(input int len, input bit with_er);
    nib_q = {}; er_q = {};
    for (int i = 0; i < len; i++) begin
      nib_q.push_back(4'($urandom));
      er_q.push_back(with_er ? 1'($urandom) : 1'b0);
    end
  endtask

  initial begin
    int gap, h, l, en_hi;
    rst_n = 1'b0; speed_100 = 1'b1; mii_txd = 4'h0; mii_tx_en = 1'b0; mii_tx_er = 1'b0;
    #2;
    check("rst_tx_clk", 32'(mii_tx_clk), 32'(0));
    check("rst_rmii_txd", 32'(rmii_txd), 32'(0));
    check("rst_rmii_tx_en", 32'(rmii_tx_en), 32'(0));
    check("rst_pulses", 32'({tx_err_pulse, odd_nibble_pulse}), 32'(0));
    check("rst_err_count", 32'(err_count), 32'(0));
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_rise", 32'(mii_tx_clk), 32'(1));

    nib_q = {4'h5, 4'h5, 4'hD, 4'hA}; er_q = {0, 0, 0, 0};
    run_frame("f100_55DA");

    random_frame(6, 0);
    er_q[1] = 1; er_q[2] = 1; er_q[4] = 1;
    run_frame("f100_err3");

    mon_q = {}; n_err_pulse = 0;
    repeat (3) begin
      wait_rise(gap);
      mii_tx_en = 1'b0; mii_tx_er = 1'b1; mii_txd = 4'($urandom);
    end
    wait_rise(gap);
    mii_tx_er = 1'b0;
    check("idle_er_pulses", 32'(n_err_pulse), 32'(0));
    check("idle_er_no_data", 32'(mon_q.size()), 32'(0));

    random_frame(7, 1);
    run_frame("f100_odd7");
    random_frame(8, 1);
    run_frame("f100_even8");

    wait_rise(gap);
    mii_tx_en = 1'b1; mii_txd = 4'hB;
    wait_rise(gap);
    wait_rise(gap);
    #3;
    check("pre_rst_tx_en", 32'(rmii_tx_en), 32'(1));
    rst_n = 1'b0; mii_tx_en = 1'b0;
    #1;
    check("midrst_tx_en", 32'(rmii_tx_en), 32'(0));
    check("midrst_txd", 32'(rmii_txd), 32'(0));
    check("midrst_tx_clk", 32'(mii_tx_clk), 32'(0));
    check("midrst_err_count", 32'(err_count), 32'(0));
    exp_err_total = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rise", 32'(mii_tx_clk), 32'(1));
    en_hi = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rmii_tx_en !== 1'b0) en_hi++;
    end
    check("post_rst_tx_en_low", 32'(en_hi), 32'(0));

    random_frame(6, 0);
    switch_at = 2;
    run_frame("f_speed_switch");
    switch_at = -1;
    cur_half = 10;
    wait_rise(gap);
    check("gap_10m", 32'(gap), 32'(20));
    h = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mii_tx_clk === 1'b1) h++; else break;
    end
    l = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mii_tx_clk === 1'b0) l++; else break;
    end
    check("tx_clk_high_10m", 32'(h), 32'(10));
    check("tx_clk_low_10m", 32'(l), 32'(10));

    nib_q = {4'h9}; er_q = {0};
    run_frame("f10_nib9");
    random_frame(5, 1);
    run_frame("f10_rand5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
